// File: rtl/lc3b_types.sv
// Shared types for the LC-3b L1 cache: word/tag/index types, controller states, address field bounds.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lc3b_types;

   typedef logic [15:0] lc3b_word;
   typedef logic [8:0]  lc3b_tag;
   typedef logic [2:0]  lc3b_c_index;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      FETCH     = 2'd2
   } cache_state_t;

   localparam int TAG_MSB = 15;
   localparam int TAG_LSB = 7;
   localparam int IDX_MSB = 6;
   localparam int IDX_LSB = 4;

endpackage

// File: rtl/cache_lru_array.sv
// Per-set LRU bit storage; each bit names the least-recently-used way of its set.
// Latency: combinational read, write takes effect on the next rising edge.
// Backpressure: none; a write is accepted every cycle the enable is high.
module cache_lru_array #(
   parameter int NUM_SETS = 8,
   parameter int IDX_W    = 3
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [IDX_W-1:0] idx,
   input  logic             we,
   input  logic             wval,
   output logic             rval
);

   logic [NUM_SETS-1:0] lru_q;

   // One flop per set, cleared to way 0 on reset, written at the addressed set only.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lru_q <= '0;
      end else if (we) begin
         lru_q[idx] <= wval;
      end
   end

   assign rval = lru_q[idx];

endmodule

// File: rtl/cache_control.sv
// Controller FSM for the 2-way L1: hits, dirty-victim writeback, line fetch; optional CACHE_PERF_CNT_EN counters.
// Latency: hit answers in the request cycle; clean miss pmem+1 cycles; dirty miss 2*pmem+1 cycles.
// Backpressure: CPU request is held until mem_resp; each pmem request is held until the pmem_resp pulse.
module cache_control
   import lc3b_types::*;
#(
   parameter int NUM_SETS = 8,
   parameter int IDX_W    = 3
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        mem_read,
   input  logic        mem_write,
   input  lc3b_word    mem_addr,
   input  logic        hit,
   input  logic        way_hit,
   input  logic        dirty0,
   input  logic        dirty1,
   input  logic        pmem_resp,
   output logic        mem_resp,
   output logic        pmem_read,
   output logic        pmem_write,
   output logic        pmem_addr_sel,
   output logic        way_sel,
   output logic [1:0]  load_data,
   output logic [1:0]  load_tag,
   output logic [1:0]  load_valid,
   output logic [1:0]  load_dirty,
   output logic        dirty_in,
   output logic        data_sel
`ifdef CACHE_PERF_CNT_EN
   ,
   output logic [15:0] hit_count,
   output logic [15:0] miss_count
`endif
);

   cache_state_t     state_q;
   logic             victim_q;
   logic [IDX_W-1:0] idx;
   logic             req;
   logic             lru_way;
   logic             victim_dirty;
   logic             lru_we;
   logic             unused_addr_bits;

   assign idx              = mem_addr[IDX_LSB +: IDX_W];
   assign unused_addr_bits = ^{mem_addr[TAG_MSB:TAG_LSB], mem_addr[IDX_LSB-1:0]};
   assign req              = mem_read | mem_write;
   assign victim_dirty     = lru_way ? dirty1 : dirty0;
   // Any hit in IDLE makes the hitting way most-recently-used.
   assign lru_we           = (state_q == IDLE) && req && hit;

   cache_lru_array #(
      .NUM_SETS (NUM_SETS),
      .IDX_W    (IDX_W)
   ) u_lru (
      .clk     (clk),
      .reset_n (reset_n),
      .idx     (idx),
      .we      (lru_we),
      .wval    (~way_hit),
      .rval    (lru_way)
   );

   // State sequencing; the victim way is captured when leaving IDLE on a miss.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         victim_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req && !hit) begin
                  victim_q <= lru_way;
                  state_q  <= victim_dirty ? WRITEBACK : FETCH;
               end
            end
            WRITEBACK: if (pmem_resp) state_q <= FETCH;
            FETCH:     if (pmem_resp) state_q <= IDLE;
            default:   state_q <= IDLE;
         endcase
      end
   end

   // Per-state outputs plus hit terms in IDLE; held at zero while reset is asserted.
   always_comb begin
      mem_resp      = 1'b0;
      pmem_read     = 1'b0;
      pmem_write    = 1'b0;
      pmem_addr_sel = 1'b0;
      way_sel       = 1'b0;
      load_data     = 2'b00;
      load_tag      = 2'b00;
      load_valid    = 2'b00;
      load_dirty    = 2'b00;
      dirty_in      = 1'b0;
      data_sel      = 1'b0;
      if (reset_n) begin
         case (state_q)
            IDLE: begin
               if (req && hit) begin
                  mem_resp = 1'b1;
                  if (mem_write) begin
                     way_sel             = way_hit;
                     load_data[way_hit]  = 1'b1;
                     load_dirty[way_hit] = 1'b1;
                     dirty_in            = 1'b1;
                  end
               end
            end
            WRITEBACK: begin
               pmem_write    = 1'b1;
               pmem_addr_sel = 1'b1;
               way_sel       = victim_q;
            end
            FETCH: begin
               pmem_read = 1'b1;
               way_sel   = victim_q;
               if (pmem_resp) begin
                  load_data[victim_q]  = 1'b1;
                  load_tag[victim_q]   = 1'b1;
                  load_valid[victim_q] = 1'b1;
                  load_dirty[victim_q] = 1'b1;
                  data_sel             = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef CACHE_PERF_CNT_EN
   // Saturating hit/miss counters, sampled on IDLE decisions only.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else if (state_q == IDLE && req) begin
         if (hit) begin
            if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
         end else begin
            if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_cache_control.sv
// Self-checking bench for cache_control: directed plan cases plus random traffic against a cache model.
// Latency: n/a.
// Backpressure: n/a.
module tb_cache_control;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        mem_read, mem_write;
   logic [15:0] mem_addr;
   logic        hit, way_hit, dirty0, dirty1, pmem_resp;
   logic        mem_resp, pmem_read, pmem_write, pmem_addr_sel, way_sel;
   logic [1:0]  load_data, load_tag, load_valid, load_dirty;
   logic        dirty_in, data_sel;
`ifdef CACHE_PERF_CNT_EN
   logic [15:0] hit_count, miss_count;
`endif

   int checks = 0;
   int errors = 0;

   // Behavioural cache model: tags, valid, dirty, LRU per set, plus event tallies.
   logic [8:0] m_tag   [8][2];
   logic       m_valid [8][2];
   logic       m_dirty [8][2];
   logic       m_lru   [8];
   int         m_hits;
   int         m_miss;

   cache_control dut (
      .clk(clk), .reset_n(reset_n), .mem_read(mem_read), .mem_write(mem_write),
      .mem_addr(mem_addr), .hit(hit), .way_hit(way_hit), .dirty0(dirty0), .dirty1(dirty1),
      .pmem_resp(pmem_resp), .mem_resp(mem_resp), .pmem_read(pmem_read),
      .pmem_write(pmem_write), .pmem_addr_sel(pmem_addr_sel), .way_sel(way_sel),
      .load_data(load_data), .load_tag(load_tag), .load_valid(load_valid),
      .load_dirty(load_dirty), .dirty_in(dirty_in), .data_sel(data_sel)
`ifdef CACHE_PERF_CNT_EN
      , .hit_count(hit_count), .miss_count(miss_count)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [14:0] obs();
      return {mem_resp, pmem_read, pmem_write, pmem_addr_sel, way_sel,
              load_data, load_tag, load_valid, load_dirty, dirty_in, data_sel};
   endfunction

   function automatic logic [14:0] expv(input logic mr, pr, pw, as, ws,
                                        input logic [1:0] ld, lt, lv, ldy,
                                        input logic di, ds);
      return {mr, pr, pw, as, ws, ld, lt, lv, ldy, di, ds};
   endfunction

   // Hit-check stand-in: looks the current address up in the model.
   task automatic drive_hit();
      logic [2:0] ix;
      ix = mem_addr[6:4];
      hit = 1'b0;
      way_hit = 1'b0;
      for (int w = 0; w < 2; w++)
         if (m_valid[ix][w] && m_tag[ix][w] == mem_addr[15:7]) begin
            hit = 1'b1;
            way_hit = 1'(w);
         end
      dirty0 = m_dirty[ix][0];
      dirty1 = m_dirty[ix][1];
   endtask

   task automatic model_reset();
      for (int s = 0; s < 8; s++) m_lru[s] = 1'b0;
      m_hits = 0;
      m_miss = 0;
   endtask

   // One full CPU transaction; entered and left just after a rising edge.
   task automatic run_req(input logic rd, input logic wr, input logic [15:0] addr, input int lat);
      logic [2:0]  ix;
      logic        v, w, dty;
      logic [1:0]  oh;
      logic [14:0] e;
      ix = addr[6:4];
      mem_read = rd; mem_write = wr; mem_addr = addr; pmem_resp = 1'b0;
      drive_hit();
      if (!hit) begin
         v   = m_lru[ix];
         dty = m_valid[ix][v] && m_dirty[ix][v];
         oh  = 2'b01 << v;
         @(negedge clk);
         checks++;
         if (obs() !== 15'd0) begin
            errors++; $display("FAIL miss_idle addr=%h got %h want %h", addr, obs(), 15'd0);
         end
         @(posedge clk); #1;
         m_miss++;
         if (dty) begin
            for (int k = 1; k <= lat; k++) begin
               pmem_resp = (k == lat);
               e = expv(0, 0, 1, 1, v, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
               @(negedge clk);
               checks++;
               if (obs() !== e) begin
                  errors++; $display("FAIL writeback addr=%h k=%0d got %h want %h", addr, k, obs(), e);
               end
               @(posedge clk); #1;
            end
         end
         for (int k = 1; k <= lat; k++) begin
            pmem_resp = (k == lat);
            if (k == lat) e = expv(0, 1, 0, 0, v, oh, oh, oh, oh, 0, 1);
            else          e = expv(0, 1, 0, 0, v, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
            @(negedge clk);
            checks++;
            if (obs() !== e) begin
               errors++; $display("FAIL fetch addr=%h k=%0d got %h want %h", addr, k, obs(), e);
            end
            @(posedge clk); #1;
         end
         pmem_resp = 1'b0;
         m_tag[ix][v] = addr[15:7]; m_valid[ix][v] = 1'b1; m_dirty[ix][v] = 1'b0;
         drive_hit();
      end
      w  = way_hit;
      oh = 2'b01 << w;
      if (wr) e = expv(1, 0, 0, 0, w, oh, 2'b00, 2'b00, oh, 1, 0);
      else    e = expv(1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
      @(negedge clk);
      checks++;
      if (obs() !== e) begin
         errors++; $display("FAIL hit addr=%h rd=%b wr=%b got %h want %h", addr, rd, wr, obs(), e);
      end
      m_lru[ix] = ~w;
      if (wr) m_dirty[ix][w] = 1'b1;
      m_hits++;
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0;
      drive_hit();
   endtask

   task automatic test_reset();
      reset_n = 1'b0; mem_read = 1'b1; mem_write = 1'b0; mem_addr = 16'h0000;
      hit = 1'b1; way_hit = 1'b0; dirty0 = 1'b0; dirty1 = 1'b0; pmem_resp = 1'b0;
      for (int s = 0; s < 8; s++)
         for (int w = 0; w < 2; w++) begin
            m_tag[s][w] = '0; m_valid[s][w] = 1'b0; m_dirty[s][w] = 1'b0;
         end
      model_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (obs() !== 15'd0) begin
         errors++; $display("FAIL reset_outputs got %h want %h", obs(), 15'd0);
      end
      mem_read = 1'b0; hit = 1'b0;
      reset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_idle();
      mem_addr = 16'h1234; drive_hit();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (obs() !== 15'd0) begin
            errors++; $display("FAIL idle_quiet cyc=%0d got %h want %h", i, obs(), 15'd0);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      m_valid[0][0] = 1'b1; m_tag[0][0] = 9'h001;
      run_req(1, 0, 16'h0080, 1);
      m_valid[1][1] = 1'b1; m_tag[1][1] = 9'h001;
      run_req(0, 1, 16'h0090, 1);
      run_req(1, 0, 16'h1230, 4);
      m_valid[2][0] = 1'b1; m_tag[2][0] = 9'h010;
      m_valid[2][1] = 1'b1; m_tag[2][1] = 9'h011; m_dirty[2][1] = 1'b1;
      run_req(1, 0, {9'h010, 3'd2, 4'h0}, 1);
      run_req(1, 0, 16'h4420, 3);
      run_req(1, 1, 16'h0080, 1);
   endtask

   task automatic test_drop();
      logic [14:0] e;
      mem_read = 1'b1; mem_write = 1'b0; mem_addr = {9'h005, 3'd7, 4'h0}; pmem_resp = 1'b0;
      drive_hit();
      @(posedge clk); #1;
      m_miss++;
      mem_read = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         pmem_resp = (k == 3);
         if (k == 3) e = expv(0, 1, 0, 0, 0, 2'b01, 2'b01, 2'b01, 2'b01, 0, 1);
         else        e = expv(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
         @(negedge clk);
         checks++;
         if (obs() !== e) begin
            errors++; $display("FAIL drop_fetch k=%0d got %h want %h", k, obs(), e);
         end
         @(posedge clk); #1;
      end
      pmem_resp = 1'b0;
      m_tag[7][0] = 9'h005; m_valid[7][0] = 1'b1; m_dirty[7][0] = 1'b0;
      @(negedge clk);
      checks++;
      if (obs() !== 15'd0) begin
         errors++; $display("FAIL drop_idle got %h want %h", obs(), 15'd0);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_fetch();
      logic [14:0] e;
      mem_read = 1'b1; mem_write = 1'b0; mem_addr = {9'h007, 3'd6, 4'h0}; pmem_resp = 1'b0;
      drive_hit();
      @(posedge clk); #1;
      e = expv(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
      @(negedge clk);
      checks++;
      if (obs() !== e) begin
         errors++; $display("FAIL rst_fetch_entry got %h want %h", obs(), e);
      end
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (obs() !== 15'd0) begin
         errors++; $display("FAIL rst_async_outputs got %h want %h", obs(), 15'd0);
      end
      mem_read = 1'b0;
      drive_hit();
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      // Set 0 had way 1 as LRU before reset; reset must point the victim back at way 0.
      run_req(1, 0, {9'h060, 3'd0, 4'h0}, 2);
   endtask

   task automatic test_random();
      logic [15:0] a;
      int sel;
      for (int i = 0; i < 80; i++) begin
         a = {9'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
         sel = $urandom_range(0, 2);
         run_req(sel != 1, sel != 0, a, $urandom_range(1, 4));
      end
   endtask

   task automatic test_perf();
`ifdef CACHE_PERF_CNT_EN
      @(negedge clk);
      checks++;
      if (hit_count !== 16'(m_hits)) begin
         errors++; $display("FAIL hit_count got %0d want %0d", hit_count, m_hits);
      end
      checks++;
      if (miss_count !== 16'(m_miss)) begin
         errors++; $display("FAIL miss_count got %0d want %0d", miss_count, m_miss);
      end
      @(posedge clk); #1;
`endif
   endtask

   initial begin
      test_reset();
      test_idle();
      test_directed();
      test_perf();
      test_drop();
      test_reset_mid_fetch();
      test_random();
      test_idle();
      test_perf();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
